// File: rtl/alu_issuer.sv
// alu_issuer: initiator-side sequencer for a multicycle 64-bit ALU.
// Commands are buffered in a CMD_DEPTH-entry FIFO and issued one at a time:
// a single-cycle alu_valid_i pulse, a bounded wait for alu_valid_o, result
// capture RESULT_DELAY cycles after done, then a valid/ready response that
// carries a wrapping sequence tag. A hung ALU is abandoned after TIMEOUT
// cycles and answered with rsp_err=1, rsp_z=0.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   cmd_valid/cmd_ready            command handshake (cmd_ready = FIFO not full)
//   cmd_a, cmd_b, cmd_op           command operands and opcode
//   alu_valid_i                    one-cycle issue pulse to the ALU
//   alu_a, alu_b, alu_op           operands held from issue until the next pop
//   alu_valid_o, alu_z             ALU done pulse and result
//   rsp_valid/rsp_ready            response handshake
//   rsp_z, rsp_op, rsp_tag, rsp_err response payload (stable while held)
//   busy                           FSM not idle or FIFO non-empty
module alu_issuer #(
  parameter int unsigned CMD_DEPTH    = 4,
  parameter int unsigned TAG_W        = 4,
  parameter int unsigned RESULT_DELAY = 1,
  parameter int unsigned TIMEOUT      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [63:0]      cmd_a,
  input  logic [63:0]      cmd_b,
  input  logic [3:0]       cmd_op,
  output logic             alu_valid_i,
  output logic [63:0]      alu_a,
  output logic [63:0]      alu_b,
  output logic [3:0]       alu_op,
  input  logic             alu_valid_o,
  input  logic [63:0]      alu_z,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_z,
  output logic [3:0]       rsp_op,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             busy
);

  localparam int unsigned PTR_W    = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned TMR_W    = $clog2(TIMEOUT);
  localparam int unsigned DLY_LOAD = (RESULT_DELAY > 0) ? RESULT_DELAY - 1 : 0;
  localparam int unsigned DLY_W    = (DLY_LOAD > 0) ? $clog2(DLY_LOAD + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [63:0]        mem_a  [CMD_DEPTH];
  logic [63:0]        mem_b  [CMD_DEPTH];
  logic [3:0]         mem_op [CMD_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [63:0]        a_q, a_d;
  logic [63:0]        b_q, b_d;
  logic [3:0]         op_q, op_d;
  logic [63:0]        z_q, z_d;
  logic               err_q, err_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [DLY_W-1:0]   dly_q, dly_d;
  logic               push, pop;

  // cmd_ready is derived from the registered count, so a pop in this cycle
  // cannot open a slot for a push in the same cycle.
  assign cmd_ready = (count_q != CNT_W'(CMD_DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == S_IDLE) && (count_q != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr_q]  <= cmd_a;
      mem_b[wr_ptr_q]  <= cmd_b;
      mem_op[wr_ptr_q] <= cmd_op;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    z_d      = z_q;
    err_d    = err_q;
    tag_d    = tag_q;
    timer_d  = timer_q;
    dly_d    = dly_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          a_d     = mem_a[rd_ptr_q];
          b_d     = mem_b[rd_ptr_q];
          op_d    = mem_op[rd_ptr_q];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        // Done has priority over timer expiry in the same cycle.
        if (alu_valid_o) begin
          if (RESULT_DELAY == 0) begin
            z_d     = alu_z;
            err_d   = 1'b0;
            state_d = S_RESP;
          end else begin
            dly_d   = DLY_W'(DLY_LOAD);
            state_d = S_CAPTURE;
          end
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          z_d     = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_CAPTURE: begin
        if (dly_q == '0) begin
          z_d     = alu_z;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else begin
          dly_d = dly_q - DLY_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          tag_d   = tag_q + TAG_W'(1);
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      z_q      <= '0;
      err_q    <= 1'b0;
      tag_q    <= '0;
      timer_q  <= '0;
      dly_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      z_q      <= z_d;
      err_q    <= err_d;
      tag_q    <= tag_d;
      timer_q  <= timer_d;
      dly_q    <= dly_d;
    end
  end

  assign alu_valid_i = (state_q == S_ISSUE);
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_op      = op_q;
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_z       = z_q;
  assign rsp_op      = op_q;
  assign rsp_tag     = tag_q;
  assign rsp_err     = err_q;
  assign busy        = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_alu_issuer.sv
// Self-checking bench for alu_issuer: a behavioural ALU model, a command
// driver that records expected responses at acceptance time, and a monitor
// that compares every presented response against the queue head.
module tb_alu_issuer;

  localparam int TB_DEPTH   = 4;
  localparam int TB_TAG_W   = 4;
  localparam int TB_RDELAY  = 1;
  localparam int TB_TIMEOUT = 16;
  localparam int NEVER      = -1;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [63:0] cmd_a, cmd_b;
  logic [3:0]  cmd_op;
  logic        alu_valid_i;
  logic [63:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic        alu_valid_o;
  logic [63:0] alu_z;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_z;
  logic [3:0]  rsp_op;
  logic [TB_TAG_W-1:0] rsp_tag;
  logic        rsp_err, busy;

  logic alu_done_m, spur_done;
  assign alu_valid_o = alu_done_m | spur_done;

  alu_issuer #(
    .CMD_DEPTH(TB_DEPTH),
    .TAG_W(TB_TAG_W),
    .RESULT_DELAY(TB_RDELAY),
    .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_valid_i(alu_valid_i), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_valid_o(alu_valid_o), .alu_z(alu_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_z(rsp_z), .rsp_op(rsp_op), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .busy(busy)
  );

  typedef struct {
    logic [63:0] z;
    logic [3:0]  op;
    logic [3:0]  tag;
    logic        err;
  } exp_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  op;
    int          d;
  } iss_t;

  exp_t exp_q[$];
  iss_t iss_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   issue_cnt = 0;
  int   issue_cyc = 0;
  int   acc_cyc = 0;
  int   gen = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Expected response is fixed at acceptance: ALU answers a+b unless it
  // never signals done, in which case the command errors out with z=0.
  task automatic push_cmd(input logic [63:0] a, input logic [63:0] b,
                          input logic [3:0] op, input int d);
    int   budget;
    bit   ok;
    logic rdy;
    int   c;
    exp_t e;
    iss_t it;
    budget = 400;
    ok = 1'b0;
    c = 0;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    cmd_valid = 1'b1;
    while (!ok && budget > 0) begin
      @(negedge clk);
      rdy = cmd_ready;
      c = cyc;
      @(posedge clk);
      if (rdy && !rst) begin
        ok = 1'b1;
        acc_cyc = c;
        e.err = (d == NEVER);
        e.z   = e.err ? 64'd0 : a + b;
        e.op  = op;
        e.tag = 4'(n_acc % (1 << TB_TAG_W));
        n_acc++;
        exp_q.push_back(e);
        it.a = a;
        it.b = b;
        it.op = op;
        it.d = d;
        iss_q.push_back(it);
      end
      #1;
      budget--;
    end
    cmd_valid = 1'b0;
    if (!ok) fail("cmd_accept_timeout");
  endtask

  task automatic wait_rsp(output int c);
    int budget;
    budget = 200;
    c = -1;
    while (budget > 0) begin
      @(negedge clk);
      if (rsp_valid) begin
        c = cyc;
        break;
      end
      budget--;
    end
    if (c < 0) fail("rsp_wait_timeout");
  endtask

  task automatic wait_drain(input int budget);
    bit done;
    done = 1'b0;
    while (!done && budget > 0) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) done = 1'b1;
      budget--;
    end
    if (!done) fail("drain_timeout");
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    gen++;
    exp_q.delete();
    iss_q.delete();
    n_acc = 0;
    issue_cnt = 0;
    cmd_valid = 1'b0;
    #1;
    chk("rst_alu_valid_i", 64'(alu_valid_i), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_rsp_tag", 64'(rsp_tag), 64'd0);
    chk("rst_rsp_z", rsp_z, 64'd0);
    chk("rst_alu_a", alu_a, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Behavioural ALU: checks operands at issue, pulses done d cycles later,
  // and presents the result only on the cycle after done.
  initial begin
    iss_t it;
    int   g;
    alu_done_m = 1'b0;
    alu_z = '0;
    forever begin
      @(negedge clk);
      if (!rst && alu_valid_i) begin
        issue_cnt++;
        issue_cyc = cyc;
        if (iss_q.size() == 0) begin
          fail("alu_issue_unexpected");
        end else begin
          it = iss_q.pop_front();
          chk("alu_a", alu_a, it.a);
          chk("alu_b", alu_b, it.b);
          chk("alu_op", 64'(alu_op), 64'(it.op));
          if (it.d != NEVER) begin
            g = gen;
            repeat (it.d) @(posedge clk);
            #1;
            if (g == gen) begin
              alu_done_m = 1'b1;
              @(posedge clk);
              #1;
              alu_done_m = 1'b0;
              alu_z = it.a + it.b;
              @(posedge clk);
              #1;
              alu_z = {$urandom, $urandom};
            end
          end
        end
      end
    end
  end

  // Response monitor: every cycle a response is presented it must match the
  // oldest outstanding expectation; it retires on the handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid) begin
        if (exp_q.size() == 0) begin
          fail("rsp_unexpected");
        end else begin
          e = exp_q[0];
          chk("rsp_z", rsp_z, e.z);
          chk("rsp_op", 64'(rsp_op), 64'(e.op));
          chk("rsp_tag", 64'(rsp_tag), 64'(e.tag));
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
          if (rsp_ready) e = exp_q.pop_front();
        end
      end
    end
  end

  initial begin
    #2000000;
    fail("global_timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "global timeout");
  end

  initial begin
    int c;
    bit stim_done;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_a = '0;
    cmd_b = '0;
    cmd_op = '0;
    rsp_ready = 1'b0;
    spur_done = 1'b0;
    do_reset();

    // Single op: accept at T, issue at T+2, response at T+8.
    rsp_ready = 1'b1;
    push_cmd(64'd5, 64'd3, 4'd1, 4);
    wait_rsp(c);
    chk("single_latency", 64'(c - acc_cyc), 64'd8);
    chk("single_issue_lat", 64'(issue_cyc - acc_cyc), 64'd2);
    wait_drain(100);
    chk("single_issue_cnt", 64'(issue_cnt), 64'd1);

    // Fill with response backpressure.
    do_reset();
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_cmd(64'(100 + i), 64'(i), 4'(i), 4);
    @(negedge clk);
    chk("fill_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("fill_busy", 64'(busy), 64'd1);
    align();
    fork
      push_cmd(64'd200, 64'd7, 4'd9, 4);
      begin
        int c0;
        wait_rsp(c0);
        repeat (10) begin
          @(negedge clk);
          chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
        end
        chk("hold_no_reissue", 64'(issue_cnt), 64'd1);
        chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
        align();
        rsp_ready = 1'b1;
      end
    join
    wait_drain(400);
    chk("fill_issue_cnt", 64'(issue_cnt), 64'd6);

    // Timeout, recovery, and done coinciding with expiry.
    do_reset();
    rsp_ready = 1'b1;
    push_cmd(64'hDEAD, 64'h1, 4'd2, NEVER);
    wait_rsp(c);
    chk("timeout_latency", 64'(c - issue_cyc), 64'(TB_TIMEOUT + 1));
    wait_drain(100);
    align();
    push_cmd(64'd11, 64'd22, 4'd3, 4);
    wait_drain(100);
    align();
    push_cmd(64'd40, 64'd2, 4'd5, TB_TIMEOUT);
    wait_rsp(c);
    chk("coincident_latency", 64'(c - issue_cyc), 64'(TB_TIMEOUT + 2));
    wait_drain(100);

    // Spurious done while idle.
    align();
    spur_done = 1'b1;
    align();
    spur_done = 1'b0;
    repeat (4) @(negedge clk);
    chk("spur_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("spur_busy", 64'(busy), 64'd0);
    chk("spur_issue_cnt", 64'(issue_cnt), 64'd3);
    align();
    push_cmd(64'd9, 64'd9, 4'd6, 3);
    wait_drain(100);

    // Random traffic with random backpressure; 20 commands wrap the tag.
    do_reset();
    stim_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          int d;
          d = ($urandom_range(0, 4) == 0) ? NEVER : int'($urandom_range(1, TB_TIMEOUT));
          push_cmd({$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom), d);
          repeat ($urandom_range(0, 2)) align();
        end
        stim_done = 1'b1;
      end
      begin
        while (!stim_done) begin
          align();
          rsp_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    rsp_ready = 1'b1;
    wait_drain(3000);
    chk("rand_issue_cnt", 64'(issue_cnt), 64'd20);

    // Reset during WAIT with two commands queued.
    do_reset();
    rsp_ready = 1'b1;
    push_cmd(64'd1, 64'd2, 4'd1, NEVER);
    push_cmd(64'd3, 64'd4, 4'd2, 4);
    push_cmd(64'd5, 64'd6, 4'd3, 4);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_busy", 64'(busy), 64'd1);
    do_reset();
    align();
    push_cmd(64'd7, 64'd8, 4'd4, 4);
    wait_drain(100);
    chk("post_reset_issue_cnt", 64'(issue_cnt), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
